// File: rtl/fwb_pkg.sv
// Shared types and geometry helpers for the frame window buffer.
//   rd_state_e     : replay FSM states
//   frameLen       : stored elements per frame (header + padded rows)
//   cntWidth       : counter width for a count of n (never below 1)
//   firstRowBase   : address of the first displayed row
package fwb_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DRAIN  = 2'd2
    } rd_state_e;

    function automatic int unsigned frameLen(input int unsigned hdrBytes,
                                             input int unsigned rowStride,
                                             input int unsigned activeH);
        return hdrBytes + rowStride * activeH;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bottom-up images store the last displayed row first.
    function automatic int unsigned firstRowBase(input int unsigned hdrBytes,
                                                 input int unsigned rowStride,
                                                 input int unsigned activeH,
                                                 input bit          bottomUp);
        return bottomUp ? hdrBytes + (activeH - 1) * rowStride : hdrBytes;
    endfunction

endpackage

// File: rtl/frame_window_buffer_if.sv
// Write and read stream handshakes of the frame window buffer.
//   wr_valid/wr_data/wr_ready : byte stream into the store
//   rd_valid/rd_data/rd_ready : active-window pixel stream out
//   rd_last                   : marks the final pixel of a window
// slave is the buffer side, master is the producer/consumer side.
interface frame_window_buffer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              rd_last;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one read port with registered output.
//   clk            : clock
//   we/wrBank/wrAddr/wrData : write strobe, bank, element index, data
//   re/rdBank/rdAddr        : read strobe, bank, element index
//   rdData         : read data, valid the cycle after re
module frame_bank_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 23,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wrBank,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              re,
    input  logic              rdBank,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);
    logic [DATA_W-1:0] mem [2][DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrBank][wrAddr] <= wrData;
        end
        if (re) begin
            rdData <= mem[rdBank][rdAddr];
        end
    end
endmodule

// File: rtl/frame_window_buffer.sv
// Ping-pong frame store: fills one bank from a raw byte stream while the other
// bank replays only its active pixel window in raster order.
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : write stream in, pixel stream out (see frame_window_buffer_if)
//   wr_frame_done  : one-cycle pulse after the last element of a frame is written
//   overflow_err   : sticky, write attempted while the write bank was full
//   frame_avail    : a full bank is waiting to be replayed
//   rd_start       : start replay of the oldest full bank
//   rd_busy        : replay in progress
module frame_window_buffer
    import fwb_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACTIVE_W   = 300,
    parameter int unsigned ACTIVE_H   = 100,
    parameter int unsigned ROW_STRIDE = 330,
    parameter int unsigned HDR_BYTES  = 3330,
    parameter bit          BOTTOM_UP  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    frame_window_buffer_if.slave bus,
    output logic                 wr_frame_done,
    output logic                 overflow_err,
    output logic                 frame_avail,
    input  logic                 rd_start,
    output logic                 rd_busy
);
    localparam int unsigned FRAME_LEN = frameLen(HDR_BYTES, ROW_STRIDE, ACTIVE_H);
    localparam int unsigned ADDR_W    = cntWidth(FRAME_LEN);
    localparam int unsigned X_W       = cntWidth(ACTIVE_W);
    localparam int unsigned Y_W       = cntWidth(ACTIVE_H);
    localparam int unsigned ROW0_BASE = firstRowBase(HDR_BYTES, ROW_STRIDE, ACTIVE_H, BOTTOM_UP);

    // ---------------- write side ----------------
    logic              wrBank;
    logic              rdBank;
    logic [1:0]        full;
    logic [ADDR_W-1:0] wrIdx;
    logic              wrReady;
    logic              wrFire;
    logic              wrLast;

    assign wrReady      = ~full[wrBank];
    assign bus.wr_ready = wrReady;
    assign wrFire       = bus.wr_valid & wrReady;
    assign wrLast       = wrFire && (wrIdx == ADDR_W'(FRAME_LEN - 1));

    // Write index, bank toggle, completion pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrBank        <= 1'b0;
            wrIdx         <= '0;
            wr_frame_done <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            wr_frame_done <= wrLast;
            if (bus.wr_valid && !wrReady) begin
                overflow_err <= 1'b1;
            end
            if (wrLast) begin
                wrIdx  <= '0;
                wrBank <= ~wrBank;
            end else if (wrFire) begin
                wrIdx <= wrIdx + ADDR_W'(1);
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_e         state;
    rd_state_e         stateNxt;
    logic              startC;
    logic              issueC;
    logic              releaseC;
    logic              room;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] rowBase;
    logic              xLast;
    logic              yLast;
    logic              ramVld;
    logic              ramLast;
    logic [DATA_W-1:0] ramData;
    logic [1:0]        occ;
    logic [1:0]        slot;
    logic              pop;
    logic [DATA_W-1:0] outData [2];
    logic [1:0]        outLast;

    assign xLast = (x == X_W'(ACTIVE_W - 1));
    assign yLast = (y == Y_W'(ACTIVE_H - 1));
    assign pop   = (occ != 2'd0) & bus.rd_ready;
    assign slot  = occ - {1'b0, pop};

    // A read may issue only if its data will find a free skid entry when it lands.
    always_comb begin
        room = 1'b0;
        unique case (occ)
            2'd0:    room = 1'b1;
            2'd1:    room = ~ramVld | pop;
            2'd2:    room = pop & ~ramVld;
            default: room = 1'b0;
        endcase
    end

    // Replay FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Replay FSM next state and strobes.
    always_comb begin
        stateNxt = state;
        startC   = 1'b0;
        issueC   = 1'b0;
        releaseC = 1'b0;
        unique case (state)
            RD_IDLE: begin
                if (rd_start && full[rdBank]) begin
                    startC   = 1'b1;
                    stateNxt = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (room) begin
                    issueC = 1'b1;
                    if (xLast && yLast) begin
                        stateNxt = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (pop && outLast[0]) begin
                    releaseC = 1'b1;
                    stateNxt = RD_IDLE;
                end
            end
            default: stateNxt = RD_IDLE;
        endcase
    end

    // Window walk: address = rowBase + x, rowBase stepped by one stride per row.
    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            rowBase <= ADDR_W'(ROW0_BASE);
        end else if (startC) begin
            x       <= '0;
            y       <= '0;
            rowBase <= ADDR_W'(ROW0_BASE);
        end else if (issueC) begin
            if (xLast) begin
                x <= '0;
                y <= y + Y_W'(1);
                if (BOTTOM_UP) begin
                    rowBase <= rowBase - ADDR_W'(ROW_STRIDE);
                end else begin
                    rowBase <= rowBase + ADDR_W'(ROW_STRIDE);
                end
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    // Bank ownership; a completing write and a releasing replay never hit the same bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= '0;
            rdBank <= 1'b0;
        end else begin
            if (releaseC) begin
                full[rdBank] <= 1'b0;
                rdBank       <= ~rdBank;
            end
            if (wrLast) begin
                full[wrBank] <= 1'b1;
            end
        end
    end

    frame_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we     (wrFire),
        .wrBank (wrBank),
        .wrAddr (wrIdx),
        .wrData (bus.wr_data),
        .re     (issueC),
        .rdBank (rdBank),
        .rdAddr (rowBase + ADDR_W'(x)),
        .rdData (ramData)
    );

    // Tracks the read in flight through the RAM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ramVld  <= 1'b0;
            ramLast <= 1'b0;
        end else begin
            ramVld  <= issueC;
            ramLast <= issueC & xLast & yLast;
        end
    end

    // Skid occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, ramVld} - {1'b0, pop};
        end
    end

    // Skid storage: head shifts on pop, landing data fills the first free entry.
    always_ff @(posedge clk) begin
        if (pop) begin
            outData[0] <= outData[1];
            outLast[0] <= outLast[1];
        end
        if (ramVld) begin
            if (slot == 2'd0) begin
                outData[0] <= ramData;
                outLast[0] <= ramLast;
            end else begin
                outData[1] <= ramData;
                outLast[1] <= ramLast;
            end
        end
    end

    assign bus.rd_valid = (occ != 2'd0);
    assign bus.rd_data  = outData[0];
    assign bus.rd_last  = (occ != 2'd0) & outLast[0];
    assign rd_busy      = (state != RD_IDLE);
    assign frame_avail  = full[rdBank] & (state == RD_IDLE);
endmodule
